ram_rw_arbiter: RTL and testbench
=================================

Name: ram_rw_arbiter

Overview:
- Two-to-one arbiter that merges the core's instruction-fetch port and load/store port onto the single ram_rw request interface.
- That interface feeds the AXI master interface inside the CPU-with-AXI top.
- Sits directly upstream of the AXI master interface and serialises requests with round-robin fairness.
- Holds the downstream request stable from grant until rw_ready_i, then returns data and response to the granted requester.

Parameters:
DATA_WIDTH, 64, width of rdata/wdata
ADDR_WIDTH, 64, width of request address
STRB_WIDTH, DATA_WIDTH/8, width of write mask

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
if_cen_i  in  1  fetch request valid, held until if_ready_o
if_addr_i  in  ADDR_WIDTH  fetch address
if_size_i  in  3  fetch size code
if_ready_o  out  1  one-cycle completion pulse to fetch
if_rdata_o  out  DATA_WIDTH  fetch read data, valid with if_ready_o
if_resp_o  out  2  fetch response, valid with if_ready_o
mem_cen_i  in  1  load/store request valid, held until mem_ready_o
mem_wen_i  in  1  1 = store
mem_addr_i  in  ADDR_WIDTH  load/store address
mem_size_i  in  3  load/store size code
mem_wdata_i  in  DATA_WIDTH  store data
mem_wmask_i  in  STRB_WIDTH  store byte mask
mem_ready_o  out  1  one-cycle completion pulse to load/store
mem_rdata_o  out  DATA_WIDTH  load data, valid with mem_ready_o
mem_resp_o  out  2  load/store response, valid with mem_ready_o
rw_cen_o  out  1  downstream request valid (registered)
rw_wen_o  out  1  downstream write enable (registered)
rw_addr_o  out  ADDR_WIDTH  downstream address (registered)
rw_size_o  out  3  downstream size (registered)
rw_wdata_o  out  DATA_WIDTH  downstream write data (registered)
rw_wmask_o  out  STRB_WIDTH  downstream byte mask (registered)
rw_ready_i  in  1  downstream completion pulse
rw_rdata_i  in  DATA_WIDTH  downstream read data
rw_resp_i  in  2  downstream response

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=MEM, so IF wins the first tie.
  - All rw_*_o outputs = 0.
  - if_ready_o = mem_ready_o = 0.
- States: IDLE, GNT_IF, GNT_MEM.
- IDLE:
  - Samples requests each cycle.
  - Only if_cen_i set -> GNT_IF.
  - Only mem_cen_i set -> GNT_MEM.
  - Both set -> grant the port not equal to last_grant.
  - Neither set -> stay in IDLE.
- On the grant edge:
  - Capture the granted port's fields into the rw_*_o registers; rw_cen_o=1; update last_grant.
  - IF grant forces rw_wen_o=0, rw_wdata_o=0, rw_wmask_o=0.
- GNT_x:
  - rw_*_o hold constant regardless of requester input changes.
  - Wait for rw_ready_i=1, then return to IDLE next cycle with rw_cen_o cleared on the same edge.
- Return path (combinational, zero added latency):
  - if_ready_o = rw_ready_i & (state==GNT_IF); mem_ready_o likewise for GNT_MEM.
  - if_rdata_o/mem_rdata_o = rw_rdata_i.
  - if_resp_o/mem_resp_o = rw_resp_i, gated to 0 when that port is not granted.
- Latency:
  - Request first seen in IDLE at cycle N -> rw_cen_o=1 at N+1.
  - rw_ready_i at cycle M -> requester ready at M, rw_cen_o=0 at M+1.
  - Earliest next grant is visible at M+2, so there is one mandatory IDLE bubble.
- Boundaries:
  - rw_ready_i while IDLE: ignored; no ready pulse, no state change.
  - Requester drops cen while granted: the downstream transaction still completes. The ready pulse is still issued; the requester ignores it. There is no abort.
  - A request arriving in the cycle rw_ready_i completes the other port: it is arbitrated in the following IDLE cycle.
  - Both requesting continuously: strict alternation IF, MEM, IF, MEM...
  - Reset mid-transaction: immediate return to IDLE, outputs cleared. The downstream AXI master shares rst_n, so no orphaned transaction exists.
- rw_resp_i is forwarded unmodified; error responses do not alter the FSM.

Decomposition:
- Shared package holds:
  - State encoding (IDLE/GNT_IF/GNT_MEM, 2 bits).
  - Grant-id constants (GRANT_IF=0, GRANT_MEM=1).
  - Size codes (SIZE_B=0, SIZE_H=1, SIZE_W=2, SIZE_D=3).
  - Response codes (OKAY=0, SLVERR=2, DECERR=3).
- Single flat module; no sub-module. The round-robin pick is a two-line expression.

Test Plan:
1. Reset release, if_cen_i=1, addr=0x8000_0000, size=3.
   - rw_cen_o=1 one cycle later with rw_addr_o=0x8000_0000 and rw_wen_o=0.
   - rw_ready_i pulse with rdata=0x0013_0000_0000_0513 -> if_ready_o=1 in the same cycle with that data.
   - rw_cen_o=0 the next cycle.
2. Store: mem_cen_i=1, wen=1, addr=0x8000_1008, wdata=0xDEAD_BEEF_0000_1234, wmask=0xF0.
   - rw_* outputs match, held stable for 5 cycles until rw_ready_i.
   - mem_ready_o pulses once; if_ready_o stays 0.
3. Both requests held continuously for 4 transactions.
   - Grant order IF, MEM, IF, MEM, with one IDLE cycle between each.
4. Granted IF drops if_cen_i and changes if_addr_i mid-wait.
   - rw_addr_o is unchanged; completion still pulses if_ready_o.
   - A spurious rw_ready_i while IDLE produces no ready pulse.
5. rst_n asserted while in GNT_MEM with rw_cen_o=1.
   - rw_cen_o=0 and state=IDLE immediately (asynchronously).
   - After release, the first tie is granted to IF.
6. rw_resp_i=2 (SLVERR) on a load.
   - mem_resp_o=2 with mem_ready_o; if_resp_o=0.
   - The FSM returns to IDLE normally.

Source files
------------

// File: rtl/ram_rw_arbiter_pkg.sv
// Shared encodings for the ram_rw request arbiter: FSM states, grant ids,
// transfer size codes and response codes.
package ram_rw_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } arb_state_e;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

endpackage

// File: rtl/ram_rw_arbiter.sv
// Round-robin arbiter merging instruction fetch and load/store onto the single
// ram_rw interface; the granted request is held in registers until rw_ready_i.
module ram_rw_arbiter
    import ram_rw_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_cen_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic [2:0]            if_size_i,
    output logic                  if_ready_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic [1:0]            if_resp_o,

    input  logic                  mem_cen_i,
    input  logic                  mem_wen_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [2:0]            mem_size_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    input  logic [STRB_WIDTH-1:0] mem_wmask_i,
    output logic                  mem_ready_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic [1:0]            mem_resp_o,

    output logic                  rw_cen_o,
    output logic                  rw_wen_o,
    output logic [ADDR_WIDTH-1:0] rw_addr_o,
    output logic [2:0]            rw_size_o,
    output logic [DATA_WIDTH-1:0] rw_wdata_o,
    output logic [STRB_WIDTH-1:0] rw_wmask_o,
    input  logic                  rw_ready_i,
    input  logic [DATA_WIDTH-1:0] rw_rdata_i,
    input  logic [1:0]            rw_resp_i
);

    arb_state_e state, state_nxt;
    logic       last_grant;
    logic       pick_if, pick_mem;

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pick_if   = 1'b0;
        pick_mem  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not win last time goes next.
                pick_if  = if_cen_i & (~mem_cen_i | (last_grant == GRANT_MEM));
                pick_mem = mem_cen_i & ~pick_if;
                if (pick_if)       state_nxt = GNT_IF;
                else if (pick_mem) state_nxt = GNT_MEM;
            end
            GNT_IF, GNT_MEM: begin
                if (rw_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_MEM;
        end else begin
            state <= state_nxt;
            if (pick_if)       last_grant <= GRANT_IF;
            else if (pick_mem) last_grant <= GRANT_MEM;
        end
    end

    // Downstream request is loaded only on the grant edge and then frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_cen_o   <= 1'b0;
            rw_wen_o   <= 1'b0;
            rw_addr_o  <= '0;
            rw_size_o  <= '0;
            rw_wdata_o <= '0;
            rw_wmask_o <= '0;
        end else if (pick_if) begin
            rw_cen_o   <= 1'b1;
            rw_wen_o   <= 1'b0;
            rw_addr_o  <= if_addr_i;
            rw_size_o  <= if_size_i;
            rw_wdata_o <= '0;
            rw_wmask_o <= '0;
        end else if (pick_mem) begin
            rw_cen_o   <= 1'b1;
            rw_wen_o   <= mem_wen_i;
            rw_addr_o  <= mem_addr_i;
            rw_size_o  <= mem_size_i;
            rw_wdata_o <= mem_wdata_i;
            rw_wmask_o <= mem_wmask_i;
        end else if (state != IDLE && rw_ready_i) begin
            rw_cen_o <= 1'b0;
        end
    end

    assign if_ready_o  = rw_ready_i & (state == GNT_IF);
    assign mem_ready_o = rw_ready_i & (state == GNT_MEM);
    assign if_rdata_o  = rw_rdata_i;
    assign mem_rdata_o = rw_rdata_i;
    assign if_resp_o   = (state == GNT_IF)  ? rw_resp_i : 2'b00;
    assign mem_resp_o  = (state == GNT_MEM) ? rw_resp_i : 2'b00;

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Directed bench for ram_rw_arbiter: a scoreboard queue holds the expected
// completion for every downstream ready pulse, checked by a separate monitor.
module tb_ram_rw_arbiter;
    import ram_rw_arbiter_pkg::*;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_cen_i;
    logic [AW-1:0] if_addr_i;
    logic [2:0]    if_size_i;
    logic          if_ready_o;
    logic [DW-1:0] if_rdata_o;
    logic [1:0]    if_resp_o;
    logic          mem_cen_i;
    logic          mem_wen_i;
    logic [AW-1:0] mem_addr_i;
    logic [2:0]    mem_size_i;
    logic [DW-1:0] mem_wdata_i;
    logic [SW-1:0] mem_wmask_i;
    logic          mem_ready_o;
    logic [DW-1:0] mem_rdata_o;
    logic [1:0]    mem_resp_o;
    logic          rw_cen_o;
    logic          rw_wen_o;
    logic [AW-1:0] rw_addr_o;
    logic [2:0]    rw_size_o;
    logic [DW-1:0] rw_wdata_o;
    logic [SW-1:0] rw_wmask_o;
    logic          rw_ready_i;
    logic [DW-1:0] rw_rdata_i;
    logic [1:0]    rw_resp_i;

    ram_rw_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_cen_i(if_cen_i), .if_addr_i(if_addr_i), .if_size_i(if_size_i),
        .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o), .if_resp_o(if_resp_o),
        .mem_cen_i(mem_cen_i), .mem_wen_i(mem_wen_i), .mem_addr_i(mem_addr_i),
        .mem_size_i(mem_size_i), .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
        .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o), .mem_resp_o(mem_resp_o),
        .rw_cen_o(rw_cen_o), .rw_wen_o(rw_wen_o), .rw_addr_o(rw_addr_o),
        .rw_size_o(rw_size_o), .rw_wdata_o(rw_wdata_o), .rw_wmask_o(rw_wmask_o),
        .rw_ready_i(rw_ready_i), .rw_rdata_i(rw_rdata_i), .rw_resp_i(rw_resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there or at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Downstream completion: queue the expected requester response, then pulse rw_ready_i for one edge.
    task automatic complete(input logic port, input logic [DW-1:0] rdata, input logic [1:0] resp);
        exp_t e;
        e.port = port; e.rdata = rdata; e.resp = resp;
        exp_q.push_back(e);
        rw_ready_i = 1'b1;
        rw_rdata_i = rdata;
        rw_resp_i  = resp;
        step();
        rw_ready_i = 1'b0;
        rw_rdata_i = '0;
        rw_resp_i  = OKAY;
        check("rw_cen_cleared_after_ready", {63'd0, rw_cen_o}, 64'd0);
    endtask

    // Monitor: every requester ready pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (if_ready_o || mem_ready_o) begin
            check("single_ready_pulse", {63'd0, if_ready_o & mem_ready_o}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ready_port", {63'd0, mem_ready_o}, {63'd0, e.port});
                if (e.port == GRANT_IF) begin
                    check("if_rdata", if_rdata_o, e.rdata);
                    check("if_resp", {62'd0, if_resp_o}, {62'd0, e.resp});
                    check("mem_resp_gated", {62'd0, mem_resp_o}, 64'd0);
                end else begin
                    check("mem_rdata", mem_rdata_o, e.rdata);
                    check("mem_resp", {62'd0, mem_resp_o}, {62'd0, e.resp});
                    check("if_resp_gated", {62'd0, if_resp_o}, 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [AW-1:0] IF_A  = 64'h8000_0100;
    localparam logic [AW-1:0] MEM_A = 64'h8000_3000;

    initial begin
        rst_n = 1'b0;
        if_cen_i = 0; if_addr_i = '0; if_size_i = '0;
        mem_cen_i = 0; mem_wen_i = 0; mem_addr_i = '0; mem_size_i = '0;
        mem_wdata_i = '0; mem_wmask_i = '0;
        rw_ready_i = 0; rw_rdata_i = '0; rw_resp_i = OKAY;
        step(); step();
        check("reset_rw_cen", {63'd0, rw_cen_o}, 64'd0);
        check("reset_rw_addr", rw_addr_o, 64'd0);
        check("reset_ready", {62'd0, if_ready_o, mem_ready_o}, 64'd0);
        rst_n = 1'b1;

        // 1: single fetch
        if_cen_i = 1; if_addr_i = 64'h8000_0000; if_size_i = SIZE_D;
        step();
        check("t1_rw_cen", {63'd0, rw_cen_o}, 64'd1);
        check("t1_rw_addr", rw_addr_o, 64'h8000_0000);
        check("t1_rw_wen", {63'd0, rw_wen_o}, 64'd0);
        check("t1_rw_size", {61'd0, rw_size_o}, 64'd3);
        complete(GRANT_IF, 64'h0013_0000_0000_0513, OKAY);
        if_cen_i = 0;

        // 2: store held stable for 5 cycles
        mem_cen_i = 1; mem_wen_i = 1; mem_addr_i = 64'h8000_1008; mem_size_i = SIZE_D;
        mem_wdata_i = 64'hDEAD_BEEF_0000_1234; mem_wmask_i = 8'hF0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t2_rw_cen", {63'd0, rw_cen_o}, 64'd1);
            check("t2_rw_wen", {63'd0, rw_wen_o}, 64'd1);
            check("t2_rw_addr", rw_addr_o, 64'h8000_1008);
            check("t2_rw_wdata", rw_wdata_o, 64'hDEAD_BEEF_0000_1234);
            check("t2_rw_wmask", {56'd0, rw_wmask_o}, 64'hF0);
            if (i < 4) step();
        end
        complete(GRANT_MEM, 64'd0, OKAY);
        mem_cen_i = 0; mem_wen_i = 0; mem_wmask_i = '0; mem_wdata_i = '0;

        // 3: both requesting continuously -> IF, MEM, IF, MEM
        if_cen_i = 1; if_addr_i = IF_A; if_size_i = SIZE_W;
        mem_cen_i = 1; mem_addr_i = MEM_A; mem_size_i = SIZE_D;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_rw_cen", {63'd0, rw_cen_o}, 64'd1);
            check("t3_grant_addr", rw_addr_o, (i % 2 == 0) ? IF_A : MEM_A);
            check("t3_rw_wen", {63'd0, rw_wen_o}, 64'd0);
            complete((i % 2 == 0) ? GRANT_IF : GRANT_MEM, 64'h1111_0000 + 64'(i), OKAY);
        end
        if_cen_i = 0; mem_cen_i = 0;

        // 4: granted fetch drops cen and changes address mid-wait
        if_cen_i = 1; if_addr_i = 64'h8000_0040;
        step();
        check("t4_rw_addr", rw_addr_o, 64'h8000_0040);
        if_cen_i = 0; if_addr_i = 64'h0000_1234;
        step(); step();
        check("t4_rw_addr_held", rw_addr_o, 64'h8000_0040);
        check("t4_rw_cen_held", {63'd0, rw_cen_o}, 64'd1);
        complete(GRANT_IF, 64'hCAFE_F00D, OKAY);
        step();
        rw_ready_i = 1; rw_rdata_i = 64'h5555; rw_resp_i = SLVERR;
        #1;
        check("t4_spurious_ready", {62'd0, if_ready_o, mem_ready_o}, 64'd0);
        check("t4_spurious_resp", {60'd0, if_resp_o, mem_resp_o}, 64'd0);
        step();
        rw_ready_i = 0; rw_rdata_i = '0; rw_resp_i = OKAY;
        check("t4_idle_after_spurious", {63'd0, rw_cen_o}, 64'd0);

        // 5: asynchronous reset while in GNT_MEM
        mem_cen_i = 1; mem_wen_i = 0; mem_addr_i = 64'h8000_2000;
        step();
        check("t5_rw_cen_before_reset", {63'd0, rw_cen_o}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rw_cen_async_clear", {63'd0, rw_cen_o}, 64'd0);
        check("t5_rw_addr_async_clear", rw_addr_o, 64'd0);
        check("t5_state_idle", {62'd0, dut.state}, 64'(IDLE));
        if_cen_i = 1; if_addr_i = IF_A;
        step();
        rst_n = 1'b1;
        step();
        check("t5_first_tie_if", rw_addr_o, IF_A);
        complete(GRANT_IF, 64'hABCD, OKAY);
        if_cen_i = 0;

        // 6: SLVERR on a load
        step();
        check("t6_grant_mem", rw_addr_o, 64'h8000_2000);
        complete(GRANT_MEM, 64'h7777_0000, SLVERR);
        mem_cen_i = 0;
        step();
        check("t6_idle", {63'd0, rw_cen_o}, 64'd0);
        if_cen_i = 1; if_addr_i = 64'h8000_0200;
        step();
        check("t6_next_grant", rw_addr_o, 64'h8000_0200);
        complete(GRANT_IF, 64'h9999, DECERR);
        if_cen_i = 0;

        step(); step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
